// File: rtl/vector_pkg.sv
// Shared types and sizes for the vector writeback path.
// Entries carry a destination register and a 4-lane vector.
package vector_pkg;

  localparam int VECTORSPERREG = 4;
  localparam int DATAWIDTH     = 16;
  localparam int NUMREGS       = 15;
  localparam int REGADDRW      = 4;
  localparam int DEPTH         = 4;
  localparam int PTRW          = $clog2(DEPTH);
  localparam int CNTW          = PTRW + 1;

  typedef logic signed [VECTORSPERREG-1:0][DATAWIDTH-1:0] vec_t;

  typedef struct packed {
    logic                valid;
    logic [REGADDRW-1:0] rd;
    vec_t                data;
  } wb_entry_t;

endpackage

// File: rtl/vector_wb_fwd_match.sv
// Youngest-match search over the writeback entry array.
// Walks oldest to youngest from head so the last hit wins.
module vector_wb_fwd_match
  import vector_pkg::*;
(
  input  wb_entry_t [DEPTH-1:0] ent_i,
  input  logic [PTRW-1:0]       head_i,
  input  logic [REGADDRW-1:0]   addr_i,
  output logic                  hit_o,
  output vec_t                  data_o
);

  logic [PTRW-1:0] idx;

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PTRW'(i);
      if (ent_i[idx].valid && ent_i[idx].rd == addr_i) begin
        hit_o  = 1'b1;
        data_o = ent_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/vector_wb_queue.sv
// In-order writeback queue behind the vector ALU with
// register-file drain, operand forwarding and stall detect.
module vector_wb_queue
  import vector_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_we,
  input  logic [REGADDRW-1:0] issue_rd,
  output logic                issue_ready,
  input  vec_t                alu_result,
  output logic                rf_we,
  output logic [REGADDRW-1:0] rf_wa,
  output vec_t                rf_wd,
  input  logic                rf_ready,
  input  logic [REGADDRW-1:0] fwd_addr_a,
  input  logic [REGADDRW-1:0] fwd_addr_b,
  output logic                fwd_hit_a,
  output logic                fwd_hit_b,
  output vec_t                fwd_data_a,
  output vec_t                fwd_data_b,
  output logic                fwd_stall,
  output logic [CNTW-1:0]     count,
  output logic                drop_err
);

  wb_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [PTRW-1:0]       head_q, head_d;
  logic [PTRW-1:0]       tail_q, tail_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [REGADDRW-1:0]   pend_rd_q, pend_rd_d;
  logic                  drop_err_q, drop_err_d;

  logic            empty, push, pop;
  logic            rd_ok, accept, drop;
  logic [CNTW:0]   occ;

  assign empty = (count_q == '0);
  assign pop   = !empty && rf_ready;
  assign push  = pend_valid_q;
  assign rd_ok = (issue_rd < REGADDRW'(NUMREGS));

  // Pending op reserves a slot, so acceptance never overflows.
  assign occ         = {1'b0, count_q} + (CNTW+1)'(pend_valid_q);
  assign issue_ready = (occ < (CNTW+1)'(DEPTH));

  assign accept = issue_valid && issue_we && issue_ready && rd_ok;
  assign drop   = issue_valid && issue_we && !rd_ok;

  always_comb begin
    ent_d        = ent_q;
    head_d       = head_q;
    tail_d       = tail_q;
    pend_valid_d = accept;
    pend_rd_d    = accept ? issue_rd : pend_rd_q;
    drop_err_d   = drop_err_q || drop;
    if (pop) begin
      ent_d[head_q].valid = 1'b0;
      head_d = head_q + PTRW'(1);
    end
    if (push) begin
      ent_d[tail_q].valid = 1'b1;
      ent_d[tail_q].rd    = pend_rd_q;
      ent_d[tail_q].data  = alu_result;
      tail_d = tail_q + PTRW'(1);
    end
    count_d = count_q + CNTW'(push) - CNTW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_rd_q    <= '0;
      drop_err_q   <= 1'b0;
    end else begin
      ent_q        <= ent_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      pend_rd_q    <= pend_rd_d;
      drop_err_q   <= drop_err_d;
    end
  end

  assign rf_we    = !empty;
  assign rf_wa    = empty ? '0 : ent_q[head_q].rd;
  assign rf_wd    = empty ? '0 : ent_q[head_q].data;
  assign count    = count_q;
  assign drop_err = drop_err_q;

  assign fwd_stall = pend_valid_q &&
    (pend_rd_q == fwd_addr_a || pend_rd_q == fwd_addr_b);

  vector_wb_fwd_match u_fwd_a (
    .ent_i  (ent_q),
    .head_i (head_q),
    .addr_i (fwd_addr_a),
    .hit_o  (fwd_hit_a),
    .data_o (fwd_data_a)
  );

  vector_wb_fwd_match u_fwd_b (
    .ent_i  (ent_q),
    .head_i (head_q),
    .addr_i (fwd_addr_b),
    .hit_o  (fwd_hit_b),
    .data_o (fwd_data_b)
  );

endmodule

// File: tb/tb_vector_wb_queue.sv
// Directed bench for vector_wb_queue: capture latency, drain
// order, forwarding, stall, back-pressure, drop and reset.
module tb_vector_wb_queue;
  import vector_pkg::*;

  logic        clk, rst;
  logic        issue_valid, issue_we, issue_ready;
  logic [3:0]  issue_rd, rf_wa, fwd_addr_a, fwd_addr_b;
  logic [63:0] alu_result, rf_wd, fwd_data_a, fwd_data_b;
  logic        rf_we, rf_ready;
  logic        fwd_hit_a, fwd_hit_b, fwd_stall, drop_err;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  vector_wb_queue dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_we    (issue_we),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .alu_result  (alu_result),
    .rf_we       (rf_we),
    .rf_wa       (rf_wa),
    .rf_wd       (rf_wd),
    .rf_ready    (rf_ready),
    .fwd_addr_a  (fwd_addr_a),
    .fwd_addr_b  (fwd_addr_b),
    .fwd_hit_a   (fwd_hit_a),
    .fwd_hit_b   (fwd_hit_b),
    .fwd_data_a  (fwd_data_a),
    .fwd_data_b  (fwd_data_b),
    .fwd_stall   (fwd_stall),
    .count       (count),
    .drop_err    (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] v4(int a, int b, int c, int d);
    return {a[15:0], b[15:0], c[15:0], d[15:0]};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int exp_rd[3] = '{3, 4, 9};

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0;
    issue_we = 1'b1;
    issue_rd = '0;
    alu_result = '0;
    rf_ready = 1'b0;
    fwd_addr_a = '0;
    fwd_addr_b = '0;
    cyc();
    cyc();
    chk("rst_count", count, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_wd", rf_wd, 0);
    chk("rst_hit_a", fwd_hit_a, 0);
    chk("rst_stall", fwd_stall, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_ready", issue_ready, 1);
    rst = 1'b0;
    cyc();

    // single op, two-cycle latency
    issue_valid = 1'b1;
    issue_rd = 4'd3;
    fwd_addr_a = 4'd3;
    #1;
    chk("t1_ready", issue_ready, 1);
    cyc();
    issue_valid = 1'b0;
    alu_result = v4(1, 2, 3, 4);
    #1;
    chk("t1_stall", fwd_stall, 1);
    chk("t1_we_early", rf_we, 0);
    cyc();
    chk("t1_we", rf_we, 1);
    chk("t1_wa", rf_wa, 3);
    chk("t1_wd", rf_wd, v4(1, 2, 3, 4));
    chk("t1_count", count, 1);
    chk("t1_stall_off", fwd_stall, 0);
    chk("t1_hit_a", fwd_hit_a, 1);
    chk("t1_data_a", fwd_data_a, v4(1, 2, 3, 4));
    rf_ready = 1'b1;
    cyc();
    chk("t1_count_pop", count, 0);
    chk("t1_we_pop", rf_we, 0);
    chk("t1_wd_pop", rf_wd, 0);

    // fill under back-pressure, then drain in order
    rf_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      issue_valid = (k < 4);
      issue_rd = 4'(k + 1);
      if (k > 0) alu_result = v4(k, k, k, k);
      #1;
      chk("t2_ready", issue_ready, (k < 4));
      cyc();
    end
    issue_valid = 1'b0;
    chk("t2_count", count, 4);
    chk("t2_ready_full", issue_ready, 0);
    rf_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      #1;
      chk("t2_wa", rf_wa, j);
      chk("t2_wd", rf_wd, v4(j, j, j, j));
      cyc();
    end
    chk("t2_empty", count, 0);

    // youngest match wins
    rf_ready = 1'b0;
    issue_valid = 1'b1;
    issue_rd = 4'd5;
    cyc();
    alu_result = v4(1, 1, 1, 1);
    cyc();
    issue_valid = 1'b0;
    alu_result = v4(9, 9, 9, 9);
    cyc();
    fwd_addr_a = 4'd5;
    fwd_addr_b = 4'd6;
    #1;
    chk("t3_hit_a", fwd_hit_a, 1);
    chk("t3_data_a", fwd_data_a, v4(9, 9, 9, 9));
    chk("t3_hit_b", fwd_hit_b, 0);
    chk("t3_data_b", fwd_data_b, 0);
    chk("t3_count", count, 2);
    rf_ready = 1'b1;
    cyc();
    chk("t3_hit_a1", fwd_hit_a, 1);
    chk("t3_data_a1", fwd_data_a, v4(9, 9, 9, 9));
    cyc();
    chk("t3_hit_a0", fwd_hit_a, 0);
    chk("t3_count0", count, 0);

    // stall only while result is in the ALU
    fwd_addr_a = 4'd0;
    fwd_addr_b = 4'd7;
    issue_valid = 1'b1;
    issue_rd = 4'd7;
    cyc();
    issue_valid = 1'b0;
    alu_result = v4(7, 7, 7, 7);
    #1;
    chk("t4_stall", fwd_stall, 1);
    cyc();
    chk("t4_stall_off", fwd_stall, 0);
    chk("t4_hit_b", fwd_hit_b, 1);
    chk("t4_data_b", fwd_data_b, v4(7, 7, 7, 7));
    chk("t4_wa", rf_wa, 7);
    cyc();
    chk("t4_count", count, 0);

    // push and pop together near full
    rf_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      issue_valid = (k < 4);
      issue_rd = 4'(k + 1);
      if (k > 0) alu_result = v4(10+k, 10+k, 10+k, 10+k);
      cyc();
    end
    issue_valid = 1'b0;
    chk("t5_full", count, 4);
    rf_ready = 1'b1;
    #1;
    chk("t5_ready_full", issue_ready, 0);
    cyc();
    rf_ready = 1'b0;
    issue_valid = 1'b1;
    issue_rd = 4'd9;
    #1;
    chk("t5_ready3", issue_ready, 1);
    cyc();
    issue_valid = 1'b0;
    alu_result = v4(19, 19, 19, 19);
    rf_ready = 1'b1;
    #1;
    chk("t5_ready_pend", issue_ready, 0);
    chk("t5_count_pre", count, 3);
    chk("t5_wa_pre", rf_wa, 2);
    cyc();
    chk("t5_count_same", count, 3);
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("t5_wa", rf_wa, exp_rd[j]);
      chk("t5_wd", rf_wd,
          v4(exp_rd[j]+10, exp_rd[j]+10, exp_rd[j]+10, exp_rd[j]+10));
      cyc();
    end
    chk("t5_empty", count, 0);

    // invalid rd drops, we=0 ignored
    issue_valid = 1'b1;
    issue_rd = 4'd15;
    cyc();
    issue_valid = 1'b0;
    chk("t6_drop", drop_err, 1);
    cyc();
    chk("t6_count", count, 0);
    chk("t6_we", rf_we, 0);
    issue_valid = 1'b1;
    issue_we = 1'b0;
    issue_rd = 4'd2;
    cyc();
    issue_valid = 1'b0;
    issue_we = 1'b1;
    cyc();
    chk("t6_we0_count", count, 0);
    chk("t6_drop_sticky", drop_err, 1);

    // reset while draining with an op in flight
    rf_ready = 1'b0;
    issue_valid = 1'b1;
    issue_rd = 4'd1;
    cyc();
    issue_rd = 4'd2;
    alu_result = v4(1, 1, 1, 1);
    cyc();
    issue_valid = 1'b0;
    alu_result = v4(2, 2, 2, 2);
    cyc();
    chk("t7_count2", count, 2);
    rf_ready = 1'b1;
    cyc();
    chk("t7_wa", rf_wa, 2);
    rf_ready = 1'b0;
    issue_valid = 1'b1;
    issue_rd = 4'd6;
    fwd_addr_a = 4'd6;
    cyc();
    issue_valid = 1'b0;
    chk("t7_stall", fwd_stall, 1);
    rst = 1'b1;
    #1;
    chk("t7_rst_count", count, 0);
    chk("t7_rst_we", rf_we, 0);
    chk("t7_rst_stall", fwd_stall, 0);
    chk("t7_rst_drop", drop_err, 0);
    cyc();
    rst = 1'b0;
    rf_ready = 1'b1;
    cyc();
    cyc();
    chk("t7_post_count", count, 0);
    chk("t7_post_we", rf_we, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
